syndrome_stream_serializer: RTL

Synthesizable host-side link driver for the single-FPGA decoder: sends the start-decoding message once, then for each syndrome frame sends the measurement header and the round-padded measurement payload over a ready/valid link into the decoder input FIFO. It then collects the 3-beat result message (iterations, cycles hi, cycles lo) from the decoder output FIFO and reports it. It is the parametrised hardware successor of the bench loading/collection FSM, generalised in link width, round count and PU-per-round, with optional result timeout.

---
 rtl/syndrome_stream_serializer_if.sv | 36 +++
 rtl/syndrome_stream_serializer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/syndrome_stream_serializer_if.sv
// Link bundle for the syndrome stream serializer: the syndrome frame input,
// the beat stream into the decoder input FIFO and the result stream out of
// the decoder output FIFO. The serializer takes the master modport; the
// host/decoder side takes the slave modport.
interface syndrome_stream_serializer_if #(
    parameter int SYN_W      = 12,
    parameter int LINK_WIDTH = 8
);
    logic [SYN_W-1:0]      syn_data;
    logic                  syn_valid;
    logic                  syn_ready;
    logic [LINK_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [LINK_WIDTH-1:0] res_data;
    logic                  res_valid;
    logic                  res_ready;

    modport master (
        input  syn_data, syn_valid,
        output syn_ready,
        output out_data, out_valid,
        input  out_ready,
        input  res_data, res_valid,
        output res_ready
    );

    modport slave (
        output syn_data, syn_valid,
        input  syn_ready,
        input  out_data, out_valid,
        output out_ready,
        output res_data, res_valid,
        input  res_ready
    );
endinterface

// File: rtl/syndrome_stream_serializer.sv
// Host-side link driver for the single-FPGA decoder. Sends the start message
// once per reset, then per syndrome frame sends the measurement header and the
// round-padded payload (LSB beat first), collects the 3-beat result message
// (iterations, cycles hi, cycles lo) and reports it as a one-cycle pulse.
// Optional macro SERIALIZER_TIMEOUT_EN: abandons result collection after
// TIMEOUT_CYCLES cycles without an accepted result beat and reports with
// report_timeout=1 (missing fields read as 0).
module syndrome_stream_serializer #(
    parameter int           PU_PER_ROUND            = 4,
    parameter int           ROUNDS                  = 3,
    parameter int           LINK_WIDTH              = 8,
    parameter logic [7:0]   START_DECODING_MSG      = 8'h01,
    parameter logic [7:0]   MEASUREMENT_DATA_HEADER = 8'h02,
    parameter int           TIMEOUT_CYCLES          = 1024
) (
    input  logic                          clk,
    input  logic                          reset,
    syndrome_stream_serializer_if.master  link,
    output logic                          report_valid,
    output logic [7:0]                    report_iterations,
    output logic [15:0]                   report_cycles,
    output logic                          report_timeout,
    output logic [15:0]                   frame_count,
    output logic                          busy
);

    // Each round is padded up to a whole byte; the payload buffer is padded up
    // to whole beats so the last beat's upper bits read as zero.
    localparam int ALIGNED      = ((PU_PER_ROUND + 7) / 8) * 8;
    localparam int PAYLOAD_BITS = ALIGNED * ROUNDS;
    localparam int DATA_BEATS   = (PAYLOAD_BITS + LINK_WIDTH - 1) / LINK_WIDTH;
    localparam int BUF_BITS     = DATA_BEATS * LINK_WIDTH;
    localparam int CNT_W        = $clog2(DATA_BEATS + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(DATA_BEATS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_SYN,
        HEADER,
        DATA,
        COLLECT,
        REPORT
    } state_t;

    state_t                state;
    logic [BUF_BITS-1:0]   payload_q;
    logic [CNT_W-1:0]      beat_cnt;
    logic [1:0]            res_cnt;
    logic [7:0]            iter_q;
    logic [7:0]            cyc_hi_q;
    logic [7:0]            res_byte;
    logic [LINK_WIDTH-1:0] unused_res_hi;

`ifdef SERIALIZER_TIMEOUT_EN
    logic [31:0]           to_cnt;
`endif

    // Place round k at bit k*ALIGNED, leaving the pad bits zero.
    function automatic logic [BUF_BITS-1:0] pad_frame(input logic [PU_PER_ROUND*ROUNDS-1:0] f);
        logic [BUF_BITS-1:0] r;
        r = '0;
        for (int k = 0; k < ROUNDS; k++) begin
            r[k*ALIGNED +: PU_PER_ROUND] = f[k*PU_PER_ROUND +: PU_PER_ROUND];
        end
        return r;
    endfunction

    // Select beat idx of the padded payload.
    function automatic logic [LINK_WIDTH-1:0] beat_of(input logic [BUF_BITS-1:0] p,
                                                      input logic [CNT_W-1:0]    idx);
        return LINK_WIDTH'(p >> (int'(idx) * LINK_WIDTH));
    endfunction

    // Only the low byte of a result beat carries information.
    assign res_byte      = link.res_data[7:0];
    assign unused_res_hi = link.res_data >> 8;

`ifndef SERIALIZER_TIMEOUT_EN
    // Without the timeout feature a report can never come from a timeout.
    assign report_timeout = 1'b0;
`endif

    // Link FSM: every output is registered and computed for the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            link.syn_ready    <= 1'b0;
            link.out_valid    <= 1'b0;
            link.out_data     <= '0;
            link.res_ready    <= 1'b0;
            report_valid      <= 1'b0;
            report_iterations <= 8'h00;
            report_cycles     <= 16'h0000;
            frame_count       <= 16'h0000;
            busy              <= 1'b0;
            payload_q         <= '0;
            beat_cnt          <= '0;
            res_cnt           <= 2'd0;
            iter_q            <= 8'h00;
            cyc_hi_q          <= 8'h00;
`ifdef SERIALIZER_TIMEOUT_EN
            to_cnt            <= 32'd0;
            report_timeout    <= 1'b0;
`endif
        end else begin
            report_valid <= 1'b0;
            case (state)
                IDLE: begin
                    state          <= START;
                    busy           <= 1'b1;
                    link.out_valid <= 1'b1;
                    link.out_data  <= LINK_WIDTH'(START_DECODING_MSG);
                end
                START: begin
                    if (link.out_valid && link.out_ready) begin
                        state          <= WAIT_SYN;
                        busy           <= 1'b0;
                        link.out_valid <= 1'b0;
                        link.out_data  <= '0;
                        link.syn_ready <= 1'b1;
                    end
                end
                WAIT_SYN: begin
                    if (link.syn_valid && link.syn_ready) begin
                        payload_q      <= pad_frame(link.syn_data);
                        state          <= HEADER;
                        busy           <= 1'b1;
                        link.syn_ready <= 1'b0;
                        link.out_valid <= 1'b1;
                        link.out_data  <= LINK_WIDTH'(MEASUREMENT_DATA_HEADER);
                    end
                end
                HEADER: begin
                    if (link.out_valid && link.out_ready) begin
                        state         <= DATA;
                        beat_cnt      <= '0;
                        link.out_data <= beat_of(payload_q, '0);
                    end
                end
                DATA: begin
                    if (link.out_valid && link.out_ready) begin
                        if (beat_cnt == LAST_BEAT) begin
                            state          <= COLLECT;
                            link.out_valid <= 1'b0;
                            link.out_data  <= '0;
                            link.res_ready <= 1'b1;
                            res_cnt        <= 2'd0;
                            iter_q         <= 8'h00;
                            cyc_hi_q       <= 8'h00;
`ifdef SERIALIZER_TIMEOUT_EN
                            to_cnt         <= 32'd0;
`endif
                        end else begin
                            beat_cnt      <= beat_cnt + 1'b1;
                            link.out_data <= beat_of(payload_q, beat_cnt + 1'b1);
                        end
                    end
                end
                COLLECT: begin
                    if (link.res_valid && link.res_ready) begin
`ifdef SERIALIZER_TIMEOUT_EN
                        to_cnt <= 32'd0;
`endif
                        res_cnt <= res_cnt + 2'd1;
                        case (res_cnt)
                            2'd0:    iter_q   <= res_byte;
                            2'd1:    cyc_hi_q <= res_byte;
                            default: begin
                                state             <= REPORT;
                                link.res_ready    <= 1'b0;
                                report_valid      <= 1'b1;
                                report_iterations <= iter_q;
                                report_cycles     <= {cyc_hi_q, res_byte};
                                frame_count       <= frame_count + 16'd1;
`ifdef SERIALIZER_TIMEOUT_EN
                                report_timeout    <= 1'b0;
`endif
                            end
                        endcase
                    end
`ifdef SERIALIZER_TIMEOUT_EN
                    else if ((to_cnt + 32'd1) >= 32'(TIMEOUT_CYCLES)) begin
                        // Give up on the result; fields never received stay zero.
                        state             <= REPORT;
                        link.res_ready    <= 1'b0;
                        report_valid      <= 1'b1;
                        report_iterations <= iter_q;
                        report_cycles     <= {cyc_hi_q, 8'h00};
                        frame_count       <= frame_count + 16'd1;
                        report_timeout    <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 32'd1;
                    end
`endif
                end
                REPORT: begin
                    state          <= WAIT_SYN;
                    busy           <= 1'b0;
                    link.syn_ready <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
